// File: rtl/wb_data_ram.sv
// wb_data_ram -- Wishbone classic slave RAM for the CPU data port.
//
// Single read/write cycles on 32-bit words with byte-lane selects. A
// programmable number of wait states is inserted before the response, and
// every accepted cycle is answered with exactly one ACK_O or ERR_O pulse.
//
// Parameters
//   DEPTH        memory size in 32-bit words (power of two, >= 4)
//   WAIT_CYCLES  wait states before the response (0..15)
// Ports
//   CLK_I        system clock, rising edge
//   RES_I        asynchronous active-low reset (memory contents survive it)
//   CYC_I/STB_I  a transfer is requested while both are high
//   WE_I         1 = write, 0 = read
//   ADR_I        byte address; word index is ADR_I[log2(DEPTH)+1:2]
//   SEL_I        byte-lane enables for DAT_I/DAT_O
//   DAT_I        write data
//   DAT_O        read data, registered, held outside response cycles
//   ACK_O/ERR_O  registered one-cycle termination pulses
module wb_data_ram #(
  parameter int DEPTH       = 1024,
  parameter int WAIT_CYCLES = 0
) (
  input  logic        CLK_I,
  input  logic        RES_I,
  input  logic        CYC_I,
  input  logic        STB_I,
  input  logic        WE_I,
  input  logic [31:0] ADR_I,
  input  logic [3:0]  SEL_I,
  input  logic [31:0] DAT_I,
  output logic [31:0] DAT_O,
  output logic        ACK_O,
  output logic        ERR_O
);

  localparam int          AW = $clog2(DEPTH);
  localparam logic [3:0]  WC = 4'(WAIT_CYCLES);

  typedef enum logic [1:0] {IDLE, WAIT, RESP} state_e;

  state_e         state_q, state_d;
  logic [3:0]     cnt_q, cnt_d;
  logic           ack_q, err_q;
  logic [31:0]    dat_q;
  logic           req;
  logic           adr_err;
  logic           enter_resp;
  logic [AW-1:0]  idx;

  logic [31:0]    mem_q [DEPTH];

  assign req     = CYC_I & STB_I;
  assign idx     = ADR_I[AW+1:2];
  // Misaligned, or any address bit above the RAM window set.
  assign adr_err = (ADR_I[1:0] != 2'b00) || (ADR_I[31:AW+2] != '0);

  // Next state. enter_resp marks the edge that raises the response; it is
  // also the only edge on which address/data are consumed and memory written.
  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    enter_resp = 1'b0;
    case (state_q)
      IDLE: begin
        if (req) begin
          if (WC == 4'd0) begin
            state_d    = RESP;
            enter_resp = 1'b1;
          end else begin
            state_d = WAIT;
            cnt_d   = WC;
          end
        end
      end
      WAIT: begin
        if (!req) begin
          // Master gave up: no write, no response.
          state_d = IDLE;
          cnt_d   = 4'd0;
        end else if (cnt_q == 4'd1) begin
          state_d    = RESP;
          cnt_d      = 4'd0;
          enter_resp = 1'b1;
        end else begin
          cnt_d = cnt_q - 4'd1;
        end
      end
      RESP: begin
        // Always return to IDLE so responses are separated by a cycle.
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
        cnt_d   = 4'd0;
      end
    endcase
  end

  always_ff @(posedge CLK_I or negedge RES_I) begin
    if (!RES_I) begin
      state_q <= IDLE;
      cnt_q   <= 4'd0;
      ack_q   <= 1'b0;
      err_q   <= 1'b0;
      dat_q   <= 32'd0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      ack_q   <= enter_resp & ~adr_err;
      err_q   <= enter_resp & adr_err;
      // Read data is captured with the response; write responses leave
      // DAT_O untouched.
      if (enter_resp && !WE_I)
        dat_q <= adr_err ? 32'd0 : mem_q[idx];
    end
  end

  // Storage is deliberately not reset. A reset during WAIT/RESP forces
  // state_q to IDLE, so a pending write never reaches enter_resp.
  always_ff @(posedge CLK_I) begin
    if (enter_resp && WE_I && !adr_err) begin
      for (int b = 0; b < 4; b++)
        if (SEL_I[b]) mem_q[idx][8*b +: 8] <= DAT_I[8*b +: 8];
    end
  end

  assign ACK_O = ack_q;
  assign ERR_O = err_q;
  assign DAT_O = dat_q;

endmodule

// File: doc/wb_data_ram.md
# wb_data_ram

Wishbone classic slave RAM on the CPU core's data port, directly downstream of cpu_dut's data master. It accepts single read/write cycles on 32-bit words with byte-lane selects. It inserts a programmable number of wait states and answers each cycle with exactly one ACK_O or ERR_O pulse. It serves as both the system data memory and the bench's data-side model.

## Interface
- DEPTH, 1024, memory size in 32-bit words; power of two, min 4
- WAIT_CYCLES, 0, wait states inserted before the response; 0..15
- CLK_I  in  1  system clock; all state changes on rising edge
- RES_I  in  1  reset, asynchronous, active-low
- CYC_I  in  1  bus cycle in progress
- STB_I  in  1  strobe; a transfer is requested while CYC_I & STB_I
- WE_I  in  1  1 = write, 0 = read
- ADR_I  in  32  byte address
- SEL_I  in  4  byte-lane enables; SEL_I[n] covers DAT_I/DAT_O[8n+7:8n]
- DAT_I  in  32  write data
- DAT_O  out  32  read data
- ACK_O  out  1  normal termination, one-cycle pulse
- ERR_O  out  1  error termination, one-cycle pulse

## Operation
- The FSM has three states: IDLE, WAIT and RESP.
- IDLE, when CYC_I & STB_I is sampled high:
  - If WAIT_CYCLES = 0, go to RESP.
  - Otherwise load the wait counter with WAIT_CYCLES and go to WAIT.
- WAIT:
  - Decrement the counter each cycle; go to RESP on the edge where the counter is 1.
  - If CYC_I or STB_I drops, abort: go to IDLE with no write and no response.
- RESP:
  - Assert exactly one of ACK_O or ERR_O for one cycle, then return to IDLE unconditionally.
  - The next request is sampled in IDLE, so there is at least one cycle between responses.
- Address decode uses word index ADR_I[log2(DEPTH)+1:2].
- Error conditions assert ERR_O instead of ACK_O, with no memory write:
  - ADR_I[1:0] != 0 (misaligned).
  - ADR_I >= 4*DEPTH (out of range).
- Write, when WE_I = 1 and there is no error:
  - Only lanes with SEL_I[n] = 1 are written.
  - SEL_I = 0 is a legal no-op write and is still ACKed.
  - The write commits on the rising edge that raises ACK_O.
- Read, when WE_I = 0 and there is no error:
  - DAT_O carries mem[index] for the full ACK_O cycle, with all 4 lanes driven regardless of SEL_I.
  - A read on ERR_O drives DAT_O = 0.
- DAT_O holds its last value outside response cycles.
- ADR_I, WE_I, SEL_I and DAT_I are used as sampled on the edge entering RESP. The master must hold them stable from request to response.
- A read issued after a completed write to the same word returns the new data. There is no bypass hazard, because responses are serialized.
- Reset:
  - Asynchronous on RES_I = 0: FSM goes to IDLE, wait counter = 0, ACK_O = 0, ERR_O = 0, DAT_O = 0.
  - Memory contents are not cleared and survive reset.
  - A reset asserted mid-cycle (in WAIT or RESP) drops any pending write that has not yet committed. The response pulse terminates immediately.
- After RES_I rises, the first request can be sampled on the first rising edge.

## Timing
- Latency: a request sampled at edge N yields ACK_O/ERR_O high during cycle N+1+WAIT_CYCLES.
- Maximum throughput: one transfer per WAIT_CYCLES+2 cycles.
- ACK_O and ERR_O are registered, never combinational from inputs, and never high simultaneously.
- Each response pulse is exactly one cycle, even if STB_I is held high through it.
- A request still held high in the cycle after RESP is treated as a new transfer.

## Test plan
- Reset, then write 0xDEADBEEF to 0x10 with SEL_I=1111, then read 0x10 -> each access gets one ACK_O pulse one cycle after its request (WAIT_CYCLES=0); the read returns DAT_O=0xDEADBEEF; ERR_O stays 0.
- Byte lanes: mem[0x20]=0x11223344, then write 0xAABBCCDD with SEL_I=0101 -> readback 0x11BB33DD; SEL_I=0000 write -> ACK_O and contents unchanged.
- Errors (DEPTH=1024): read 0x1002 (misaligned) and write 0x1000 (out of range) -> ERR_O pulse, no ACK_O, DAT_O=0 on the read; a subsequent read of 0x0 is unchanged.
- WAIT_CYCLES=3: request at edge N -> ACK_O high in cycle N+4 only; STB_I dropped in cycle N+2 of a write -> no response and memory unchanged.
- Back-to-back: STB_I held high over 4 reads, WAIT_CYCLES=0 -> ACK_O pattern 1,0,1,0,...; no two consecutive ACK cycles.
- Reset mid-cycle: with WAIT_CYCLES=2, write 0x5555AAAA to 0x8 and pull RES_I low in WAIT -> ACK_O=0 immediately and 0x8 keeps its old value; pre-reset contents at other addresses read back intact.
